// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants, FSM encoding and sizing helper for the bin_to_bcd_seq converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Number of decimal digits needed to print the largest bin_w-bit value.
  function automatic int digits_needed(input int bin_w);
    longint unsigned max_val;
    int              n;
    max_val = (longint'(1) << bin_w) - 1;
    n       = 1;
    while (max_val > 9) begin
      max_val = max_val / 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the converter.
// The blank vector exists only when LEADING_ZERO_BLANK_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  logic                                 start;
  logic [BIN_W-1:0]                     bin;
  logic                                 busy;
  logic                                 done;
  logic [bcd_pkg::DIGIT_W*DIGITS-1:0]   bcd;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]                    blank;

  modport master (output start, bin, input busy, done, bcd, blank);
  modport slave  (input start, bin, output busy, done, bcd, blank);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed-BCD converter with start/busy/done handshake.
// Optional LEADING_ZERO_BLANK_EN adds a registered leading-zero blanking vector.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SHIFT  = ST_SHIFT;
  localparam logic [1:0] S_FINISH = ST_FINISH;

  if (DIGITS < digits_needed(BIN_W)) begin : g_digits_too_few
    $error("bin_to_bcd_seq: DIGITS=%0d cannot hold %0d-bit values", DIGITS, BIN_W);
  end

  logic [1:0]       r_state;
  logic [BIN_W-1:0] r_shreg;
  logic [SCR_W-1:0] r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [SCR_W-1:0] r_bcd;
  logic [SCR_W-1:0] w_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_all_zero;

  // Walk from the top digit down; digit 0 always stays visible.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_blank    = '0;
    w_all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_all_zero = w_all_zero && (r_scratch[i*DIGIT_W +: DIGIT_W] == '0);
      w_blank[i] = w_all_zero;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shreg   <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Correct all digits, then shift {scratch, shreg} left by one.
          r_scratch <= (w_adj << 1) | SCR_W'(r_shreg[BIN_W-1]);
          r_shreg   <= r_shreg << 1;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_bcd   <= r_scratch;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef LEADING_ZERO_BLANK_EN
          r_blank <= w_blank;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
  assign bus.blank = r_blank;
`endif

endmodule
